capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/cs_pkg.sv | 35 +++
 rtl/capture_sequencer_if.sv | 29 ++
 rtl/zero_cross_detect.sv | 33 +++
 rtl/capture_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_capture_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cs_pkg.sv
// Shared definitions for the capture sequencer: FSM states, datapath widths,
// the debug view of internal state and the offset-binary display conversion.
package cs_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int RAM_ADDR_W = 9;
  localparam int DISP_W     = 8;
  localparam int COUNT_W    = 8;
  localparam int TIMEOUT_W  = 13;

  localparam logic [DISP_W-1:0] OFFSET_BIN = 8'h80;

  typedef enum logic [2:0] {
    ARM       = 3'd0,
    TRIG_WAIT = 3'd1,
    CAPTURE   = 3'd2,
    WAIT_IDLE = 3'd3,
    SWAP      = 3'd4
  } cs_state_t;

  typedef struct packed {
    cs_state_t            state;
    logic [COUNT_W-1:0]   sample_count;
    logic [TIMEOUT_W-1:0] timeout_count;
    logic                 forced_pending;
    logic                 neg_seen;
    logic                 pos_cross;
  } cs_debug_t;

  // Flipping the sign bit turns two's complement into offset binary.
  function automatic logic [DISP_W-1:0] to_display(input logic [DISP_W-1:0] msb);
    return msb ^ OFFSET_BIN;
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// Sample stream in, frame-buffer write port and display status out.
interface capture_sequencer_if;
  import cs_pkg::*;

  // new_sample is a one-cycle valid strobe qualifying sample in the same cycle;
  // there is no ready, so the sequencer either consumes or drops each strobe.
  // write_enable is a one-cycle valid strobe qualifying write_address and
  // write_sample; the RAM must accept it unconditionally.
  logic                  new_sample;
  logic [SAMPLE_W-1:0]   sample;
  logic                  vsync;
  logic                  auto_en;
  logic [RAM_ADDR_W-1:0] write_address;
  logic                  write_enable;
  logic [DISP_W-1:0]     write_sample;
  logic                  read_index;
  logic                  forced;

  modport master (
    output new_sample, sample, vsync, auto_en,
    input  write_address, write_enable, write_sample, read_index, forced
  );

  modport slave (
    input  new_sample, sample, vsync, auto_en,
    output write_address, write_enable, write_sample, read_index, forced
  );

endinterface

// File: rtl/zero_cross_detect.sv
// Classifies sample strobes by sign and remembers whether a negative sample
// has been seen since the last clear, flagging the following positive crossing.
module zero_cross_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic new_sample,
  input  logic sign,
  input  logic clear,
  output logic neg_sample,
  output logic pos_sample,
  output logic neg_seen,
  output logic pos_cross
);

  assign neg_sample = new_sample & sign;
  assign pos_sample = new_sample & ~sign;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_seen  <= 1'b0;
      pos_cross <= 1'b0;
    end else if (clear) begin
      neg_seen  <= 1'b0;
      pos_cross <= 1'b0;
    end else begin
      if (neg_sample) begin
        neg_seen <= 1'b1;
      end
      pos_cross <= pos_sample & neg_seen;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Oscilloscope-style frame capture: arm on a negative sample, trigger on the
// positive zero crossing (or a timeout), fill one RAM half, swap on vsync.
module capture_sequencer
  import cs_pkg::*;
#(
  parameter int NUM_SAMPLES  = 256,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  capture_sequencer_if.slave  bus,
  output cs_debug_t           debug
);

  localparam logic [COUNT_W-1:0]   LAST_INDEX    = COUNT_W'(NUM_SAMPLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(AUTO_TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX   = {TIMEOUT_W{1'b1}};

  cs_state_t state;
  cs_state_t state_next;

  logic [COUNT_W-1:0]    sample_count;
  logic [TIMEOUT_W-1:0]  timeout_count;
  logic                  forced_pending;
  logic                  vsync_prev;
  logic                  vsync_rise;

  logic [RAM_ADDR_W-1:0] write_address_q;
  logic                  write_enable_q;
  logic [DISP_W-1:0]     write_sample_q;
  logic                  read_index_q;
  logic                  forced_q;

  logic neg_sample;
  logic pos_sample;
  logic neg_seen;
  logic pos_cross;

  logic                  timed_out;
  logic                  real_trigger;
  logic                  forced_trigger;
  logic                  capture_write;
  logic                  count_strobe;
  logic                  do_swap;
  logic                  write_fire;
  logic                  last_write;
  logic [COUNT_W-1:0]    write_index;

  // Only the upper byte reaches the display; the low byte is intentionally dropped.
  logic unused_sample_bits;
  assign unused_sample_bits = ^bus.sample[SAMPLE_W-DISP_W-1:0];

  zero_cross_detect u_zero_cross_detect (
    .clk        (clk),
    .reset_n    (reset_n),
    .new_sample (bus.new_sample),
    .sign       (bus.sample[SAMPLE_W-1]),
    .clear      (do_swap),
    .neg_sample (neg_sample),
    .pos_sample (pos_sample),
    .neg_seen   (neg_seen),
    .pos_cross  (pos_cross)
  );

  assign timed_out  = bus.auto_en && (timeout_count >= TIMEOUT_LIMIT);
  assign vsync_rise = bus.vsync & ~vsync_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARM;
    end else begin
      state <= state_next;
    end
  end

  // Strobe decode; every decision looks only at the current (pre-transition) state.
  always_comb begin
    real_trigger   = 1'b0;
    forced_trigger = 1'b0;
    capture_write  = 1'b0;
    count_strobe   = 1'b0;
    do_swap        = 1'b0;
    unique case (state)
      ARM: begin
        if (bus.new_sample) begin
          if (timed_out) forced_trigger = 1'b1;
          else           count_strobe   = 1'b1;
        end
      end
      TRIG_WAIT: begin
        if (pos_sample && neg_seen) begin
          real_trigger = 1'b1;
        end else if (bus.new_sample) begin
          if (timed_out) forced_trigger = 1'b1;
          else           count_strobe   = 1'b1;
        end
      end
      CAPTURE:   capture_write = bus.new_sample;
      WAIT_IDLE: ;
      SWAP:      do_swap = 1'b1;
      default:   ;
    endcase
    write_fire  = real_trigger | forced_trigger | capture_write;
    write_index = capture_write ? sample_count : '0;
    last_write  = write_fire && (write_index == LAST_INDEX);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARM: begin
        if (forced_trigger)  state_next = last_write ? WAIT_IDLE : CAPTURE;
        else if (neg_sample) state_next = TRIG_WAIT;
      end
      TRIG_WAIT: begin
        if (real_trigger || forced_trigger) state_next = last_write ? WAIT_IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (last_write) state_next = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (vsync_rise) state_next = SWAP;
      end
      SWAP:    state_next = ARM;
      default: state_next = ARM;
    endcase
  end

  // vsync_prev resets high so a display already in blank at release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_prev      <= 1'b1;
      sample_count    <= '0;
      timeout_count   <= '0;
      forced_pending  <= 1'b0;
      write_address_q <= '0;
      write_enable_q  <= 1'b0;
      write_sample_q  <= '0;
      read_index_q    <= 1'b0;
      forced_q        <= 1'b0;
    end else begin
      vsync_prev     <= bus.vsync;
      write_enable_q <= write_fire;
      if (write_fire) begin
        write_address_q <= {~read_index_q, write_index};
        write_sample_q  <= to_display(bus.sample[SAMPLE_W-1 -: DISP_W]);
        sample_count    <= last_write ? '0 : write_index + COUNT_W'(1);
      end
      if (count_strobe && (timeout_count != TIMEOUT_MAX)) begin
        timeout_count <= timeout_count + TIMEOUT_W'(1);
      end
      if (forced_trigger) begin
        forced_pending <= 1'b1;
      end
      if (do_swap) begin
        read_index_q   <= ~read_index_q;
        forced_q       <= forced_pending;
        timeout_count  <= '0;
        forced_pending <= 1'b0;
      end
    end
  end

  assign bus.write_address = write_address_q;
  assign bus.write_enable  = write_enable_q;
  assign bus.write_sample  = write_sample_q;
  assign bus.read_index    = read_index_q;
  assign bus.forced        = forced_q;

  always_comb begin
    debug                = '0;
    debug.state          = state;
    debug.sample_count   = sample_count;
    debug.timeout_count  = timeout_count;
    debug.forced_pending = forced_pending;
    debug.neg_seen       = neg_seen;
    debug.pos_cross      = pos_cross;
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: scenario tasks plus a write
// scoreboard fed by the sample driver and drained by a write monitor.
module tb_capture_sequencer;
  import cs_pkg::*;

  localparam int EXP_W = RAM_ADDR_W + DISP_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  capture_sequencer_if bus();
  cs_debug_t dbg;

  capture_sequencer #(
    .NUM_SAMPLES  (256),
    .AUTO_TIMEOUT (4096)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .debug   (dbg)
  );

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  logic [EXP_W-1:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic monitor_writes();
    logic [EXP_W-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (reset_n && bus.write_enable) begin
        wr_pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got addr=%h data=%h exp=no write",
                   bus.write_address, bus.write_sample);
        end else begin
          exp_v = exp_q.pop_front();
          if ({bus.write_address, bus.write_sample} !== exp_v) begin
            failures++;
            $display("FAIL write_data got addr=%h data=%h exp addr=%h data=%h",
                     bus.write_address, bus.write_sample,
                     exp_v[EXP_W-1 -: RAM_ADDR_W], exp_v[DISP_W-1:0]);
          end
        end
      end
    end
  endtask

  task automatic apply_reset(input logic auto);
    @(negedge clk);
    reset_n = 1'b0;
    bus.new_sample = 1'b0;
    bus.sample = '0;
    bus.vsync = 1'b0;
    bus.auto_en = auto;
    @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
  endtask

  // One strobe; write_enable must answer exactly one cycle later.
  task automatic send_sample(input logic [15:0] s, input logic exp_wr,
                             input logic [8:0] exp_addr, input int gap);
    @(negedge clk);
    bus.new_sample = 1'b1;
    bus.sample = s;
    if (exp_wr) exp_q.push_back({exp_addr, s[15:8] ^ 8'h80});
    @(posedge clk);
    #1;
    bus.new_sample = 1'b0;
    checks++;
    if (bus.write_enable !== exp_wr) begin
      failures++;
      $display("FAIL write_latency sample=%h got we=%b exp we=%b", s, bus.write_enable, exp_wr);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic vsync_swap(input logic exp_ri, input logic exp_forced);
    @(negedge clk);
    bus.vsync = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dbg.state !== SWAP) begin
      failures++;
      $display("FAIL swap_state got=%0d exp=%0d", dbg.state, SWAP);
    end
    checks++;
    if (bus.read_index !== ~exp_ri) begin
      failures++;
      $display("FAIL read_index_in_swap got=%b exp=%b", bus.read_index, ~exp_ri);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.read_index !== exp_ri) begin
      failures++;
      $display("FAIL read_index_after_swap got=%b exp=%b", bus.read_index, exp_ri);
    end
    checks++;
    if (bus.forced !== exp_forced) begin
      failures++;
      $display("FAIL forced_after_swap got=%b exp=%b", bus.forced, exp_forced);
    end
    checks++;
    if (dbg.state !== ARM) begin
      failures++;
      $display("FAIL state_after_swap got=%0d exp=%0d", dbg.state, ARM);
    end
    @(negedge clk);
    bus.vsync = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.vsync = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.write_enable, bus.write_address, bus.write_sample, bus.read_index, bus.forced} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b addr=%h data=%h ri=%b forced=%b exp=all zero",
               bus.write_enable, bus.write_address, bus.write_sample, bus.read_index, bus.forced);
    end
    checks++;
    if (dbg.state !== ARM || dbg.sample_count !== 8'd0 || dbg.timeout_count !== 13'd0 ||
        dbg.forced_pending !== 1'b0 || dbg.neg_seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_internal got state=%0d cnt=%0d to=%0d fp=%b ns=%b exp ARM/0/0/0/0",
               dbg.state, dbg.sample_count, dbg.timeout_count, dbg.forced_pending, dbg.neg_seen);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dbg.state !== ARM || bus.write_enable !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_release got state=%0d we=%b exp state=%0d we=0",
               dbg.state, bus.write_enable, ARM);
    end
    bus.vsync = 1'b0;
  endtask

  task automatic test_first_write();
    apply_reset(1'b1);
    send_sample(16'hFF9C, 1'b0, 9'h0, 1);
    checks++;
    if (dbg.state !== TRIG_WAIT) begin
      failures++;
      $display("FAIL armed_state got=%0d exp=%0d", dbg.state, TRIG_WAIT);
    end
    send_sample(16'd50, 1'b1, 9'h100, 1);
    checks++;
    if (dbg.state !== CAPTURE || dbg.sample_count !== 8'd1) begin
      failures++;
      $display("FAIL trigger_state got state=%0d cnt=%0d exp state=%0d cnt=1",
               dbg.state, dbg.sample_count, CAPTURE);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL first_write_drained got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_full_frame();
    int start_pulses;
    logic [8:0] addr;
    apply_reset(1'b1);
    start_pulses = wr_pulses;
    send_sample(16'hFF9C, 1'b0, 9'h0, 1);
    for (int i = 0; i < 256; i++) begin
      addr = 9'h100 + 9'(i);
      send_sample(16'(i * 300), 1'b1, addr, $urandom_range(0, 2));
    end
    for (int i = 0; i < 3; i++) send_sample(16'h1234, 1'b0, 9'h0, 1);
    checks++;
    if (wr_pulses - start_pulses != 256 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL frame_write_count got=%0d left=%0d exp=256 left=0",
               wr_pulses - start_pulses, exp_q.size());
    end
    checks++;
    if (dbg.state !== WAIT_IDLE || dbg.sample_count !== 8'd0) begin
      failures++;
      $display("FAIL frame_done_state got state=%0d cnt=%0d exp state=%0d cnt=0",
               dbg.state, dbg.sample_count, WAIT_IDLE);
    end
    vsync_swap(1'b1, 1'b0);
    send_sample(16'hFFFF, 1'b0, 9'h0, 1);
    send_sample(16'h0001, 1'b1, 9'h000, 1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL second_half_drained got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_forced();
    logic [8:0] addr;
    apply_reset(1'b1);
    for (int i = 0; i < 4096; i++) send_sample(16'd1000, 1'b0, 9'h0, 1);
    checks++;
    if (dbg.timeout_count !== 13'd4096 || dbg.state !== ARM) begin
      failures++;
      $display("FAIL timeout_reached got to=%0d state=%0d exp to=4096 state=%0d",
               dbg.timeout_count, dbg.state, ARM);
    end
    for (int i = 0; i < 256; i++) begin
      addr = 9'h100 + 9'(i);
      send_sample(16'd1000, 1'b1, addr, 1);
    end
    checks++;
    if (bus.forced !== 1'b0 || dbg.forced_pending !== 1'b1 || dbg.state !== WAIT_IDLE) begin
      failures++;
      $display("FAIL forced_pending got forced=%b fp=%b state=%0d exp forced=0 fp=1 state=%0d",
               bus.forced, dbg.forced_pending, dbg.state, WAIT_IDLE);
    end
    vsync_swap(1'b1, 1'b1);
  endtask

  task automatic test_no_auto();
    int start_pulses;
    apply_reset(1'b0);
    start_pulses = wr_pulses;
    for (int i = 0; i < 10000; i++) send_sample(16'd1000, 1'b0, 9'h0, 1);
    checks++;
    if (wr_pulses != start_pulses || bus.read_index !== 1'b0 || dbg.state !== ARM) begin
      failures++;
      $display("FAIL no_auto_idle got writes=%0d ri=%b state=%0d exp writes=0 ri=0 state=%0d",
               wr_pulses - start_pulses, bus.read_index, dbg.state, ARM);
    end
    checks++;
    if (dbg.timeout_count !== 13'h1FFF) begin
      failures++;
      $display("FAIL timeout_saturate got=%0d exp=%0d", dbg.timeout_count, 13'h1FFF);
    end
    bus.auto_en = 1'b1;
    send_sample(16'd1000, 1'b1, 9'h100, 1);
    checks++;
    if (dbg.state !== CAPTURE || dbg.forced_pending !== 1'b1) begin
      failures++;
      $display("FAIL auto_en_change got state=%0d fp=%b exp state=%0d fp=1",
               dbg.state, dbg.forced_pending, CAPTURE);
    end
  endtask

  task automatic test_vsync_high();
    int start_pulses;
    logic [8:0] addr;
    apply_reset(1'b1);
    send_sample(16'h8000, 1'b0, 9'h0, 1);
    for (int i = 0; i < 256; i++) begin
      if (i == 200) bus.vsync = 1'b1;
      addr = 9'h100 + 9'(i);
      send_sample(16'(i * 64 + 1), 1'b1, addr, 0);
    end
    @(negedge clk);
    start_pulses = wr_pulses;
    for (int i = 0; i < 20; i++) send_sample(16'(16'hC000 + i), 1'b0, 9'h0, 1);
    checks++;
    if (wr_pulses != start_pulses || dbg.state !== WAIT_IDLE || bus.read_index !== 1'b0) begin
      failures++;
      $display("FAIL vsync_high_hold got writes=%0d state=%0d ri=%b exp writes=0 state=%0d ri=0",
               wr_pulses - start_pulses, dbg.state, bus.read_index, WAIT_IDLE);
    end
    bus.vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync_swap(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] addr;
    apply_reset(1'b1);
    send_sample(16'hF000, 1'b0, 9'h0, 1);
    for (int i = 0; i < 99; i++) begin
      addr = 9'h100 + 9'(i);
      send_sample(16'(16'h0100 * (i % 128)), 1'b1, addr, 1);
    end
    @(negedge clk);
    bus.new_sample = 1'b1;
    bus.sample = 16'h5A5A;
    @(posedge clk);
    #1;
    bus.new_sample = 1'b0;
    checks++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h163) begin
      failures++;
      $display("FAIL write_100_inflight got we=%b addr=%h exp we=1 addr=163",
               bus.write_enable, bus.write_address);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.write_enable, bus.write_address, bus.write_sample, bus.read_index, bus.forced} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset_outputs got we=%b addr=%h data=%h ri=%b forced=%b exp=all zero",
               bus.write_enable, bus.write_address, bus.write_sample, bus.read_index, bus.forced);
    end
    checks++;
    if (dbg.state !== ARM || dbg.sample_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset_state got state=%0d cnt=%0d exp state=%0d cnt=0",
               dbg.state, dbg.sample_count, ARM);
    end
    @(negedge clk);
    reset_n = 1'b1;
    send_sample(16'hFF9C, 1'b0, 9'h0, 1);
    send_sample(16'd50, 1'b1, 9'h100, 1);
    checks++;
    if (exp_q.size() != 0 || bus.read_index !== 1'b0) begin
      failures++;
      $display("FAIL restart_after_reset got left=%0d ri=%b exp left=0 ri=0",
               exp_q.size(), bus.read_index);
    end
  endtask

  task automatic test_back_to_back();
    int start_pulses;
    logic [15:0] s;
    logic [8:0] addr;
    apply_reset(1'b1);
    start_pulses = wr_pulses;
    send_sample(16'hFFFB, 1'b0, 9'h0, 0);
    for (int i = 0; i < 16; i++) begin
      s = (i == 0) ? 16'($urandom_range(0, 32767)) : 16'($urandom_range(0, 65535));
      addr = 9'h100 + 9'(i);
      send_sample(s, 1'b1, addr, 0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wr_pulses - start_pulses != 16 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_count got=%0d left=%0d exp=16 left=0",
               wr_pulses - start_pulses, exp_q.size());
    end
    checks++;
    if (dbg.state !== CAPTURE || dbg.sample_count !== 8'd16) begin
      failures++;
      $display("FAIL back_to_back_state got state=%0d cnt=%0d exp state=%0d cnt=16",
               dbg.state, dbg.sample_count, CAPTURE);
    end
  endtask

  initial begin
    bus.new_sample = 1'b0;
    bus.sample = '0;
    bus.vsync = 1'b0;
    bus.auto_en = 1'b1;
    fork
      monitor_writes();
    join_none
    test_reset();
    test_first_write();
    test_full_frame();
    test_forced();
    test_no_auto();
    test_vsync_high();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
